// File: rtl/imem_fetch_unit.sv
// Instruction memory with boot-load port, registered fetch and address fault detection.
// Optional IMEM_PARITY_EN stores an even-parity bit per word and flags mismatches on read.
module imem_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_last,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    input  logic                  instr_stall,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_fault,
    output logic                  parity_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                  state, state_nx;
    logic [DEPTH_LOG2-1:0]   cnt, cnt_nx;
    logic                    done_nx;
    logic                    load_fire, load_end, fetch_fire, fault;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign load_ready  = (state == LOAD);
    assign load_fire   = load_ready && load_valid;
    // The last addressable word ends the load even without load_last; no wrap.
    assign load_end    = load_last || (&cnt);
    assign fetch_ready = (state == RUN) && !(instr_valid && instr_stall) && !load_start;
    assign fetch_fire  = fetch_req && fetch_ready;
    assign idx         = fetch_addr[DEPTH_LOG2+1:2];
    assign fault       = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (DEPTH_LOG2 + 2)) != '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (load_start) state_nx = LOAD;
            LOAD: begin
                if (load_valid) begin
                    if (load_end) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + DEPTH_LOG2'(1);
                    end
                end
            end
            RUN:     if (load_start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            load_done <= done_nx;
        end
    end

    // Memory contents survive reset so a partial boot image is retained.
    always_ff @(posedge clk) begin
        if (!reset && load_fire) mem[cnt] <= load_data;
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_q;

    always_ff @(posedge clk) begin
        if (!reset && load_fire) par_mem[cnt] <= ^load_data;
    end
    assign parity_err = par_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else if (state == RUN && load_start) begin
            instr_valid <= 1'b0;
        end else if (fetch_fire) begin
            instr_valid <= 1'b1;
            instr_out   <= fault ? NOP_WORD : mem[idx];
            instr_fault <= fault;
`ifdef IMEM_PARITY_EN
            par_q       <= !fault && ((^mem[idx]) != par_mem[idx]);
`endif
        end else if (instr_valid && !instr_stall) begin
            instr_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: load, fetch, stall, fault, full load, reset mid-load.
module tb_imem_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, load_start, load_valid, load_last, fetch_req, instr_stall;
    logic [31:0] load_data, fetch_addr;
    logic        load_ready, load_done, fetch_ready, instr_valid, instr_fault, parity_err;
    logic [31:0] instr_out;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog [4] = '{32'h20080001, 32'h20090002, 32'h01095020, 32'hAC0A0000};

    imem_fetch_unit dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_last(load_last), .load_data(load_data), .load_ready(load_ready),
        .load_done(load_done), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .instr_stall(instr_stall), .instr_valid(instr_valid),
        .instr_out(instr_out), .instr_fault(instr_fault), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_words(input logic [31:0] base, input int n, input bit use_last);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        #1 chk("load_ready_in_load", load_ready, 1);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = base + i;
            load_last  = use_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        chk("load_done_pulse", load_done, 1);
        chk("load_ready_after", load_ready, 0);
        tick();
        chk("load_done_single", load_done, 0);
    endtask

    initial begin
        reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_addr = '0; instr_stall = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_load_ready", load_ready, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_fetch_ready", fetch_ready, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_fault", instr_fault, 0);
        chk("rst_parity_err", parity_err, 0);

        // Boot-load the 4-word program
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        #1 chk("load_ready", load_ready, 1);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        #1;
        chk("prog_load_done", load_done, 1);
        tick();
        chk("prog_load_done_once", load_done, 0);

        // Back-to-back fetch
        fetch_req = 1'b1; fetch_addr = 32'h0;
        #1 chk("b2b_fetch_ready", fetch_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) fetch_addr = 32'(4 * (i + 1));
            else fetch_req = 1'b0;
            #1;
            chk("b2b_valid", instr_valid, 1);
            chk("b2b_out", instr_out, prog[i]);
            chk("b2b_fault", instr_fault, 0);
            chk("b2b_parity", parity_err, 0);
        end
        tick();
        chk("b2b_drain_valid", instr_valid, 0);

        // Stall holds the output and blocks the next fetch
        fetch_req = 1'b1; fetch_addr = 32'h4;
        tick();
        fetch_addr = 32'h8; instr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_fetch_ready", fetch_ready, 0);
            chk("stall_out", instr_out, 32'h20090002);
            chk("stall_valid", instr_valid, 1);
            tick();
        end
        instr_stall = 1'b0;
        #1 chk("unstall_fetch_ready", fetch_ready, 1);
        tick();
        chk("unstall_out", instr_out, 32'h01095020);

        // Faulting addresses
        fetch_addr = 32'h6;
        tick();
        fetch_addr = 32'h400;
        #1;
        chk("mis_out", instr_out, 32'h0);
        chk("mis_fault", instr_fault, 1);
        chk("mis_valid", instr_valid, 1);
        tick();
        fetch_addr = 32'h0;
        #1;
        chk("oor_out", instr_out, 32'h0);
        chk("oor_fault", instr_fault, 1);
        chk("oor_parity", parity_err, 0);
        tick();
        fetch_req = 1'b0;
        #1;
        chk("post_fault_out", instr_out, prog[0]);
        chk("post_fault_fault", instr_fault, 0);

        // Full 256-word load without load_last; flushes the pending output
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        #1 chk("flush_valid", instr_valid, 0);
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1; load_data = 32'hA500_0000 | 32'(i);
            tick();
        end
        load_valid = 1'b0;
        #1;
        chk("full_load_done", load_done, 1);
        chk("full_load_ready", load_ready, 0);
        fetch_req = 1'b1; fetch_addr = 32'h3FC;
        tick();
        fetch_addr = 32'h0;
        #1 chk("full_w255", instr_out, 32'hA500_00FF);
        tick();
        fetch_req = 1'b0;
        #1 chk("full_w0", instr_out, 32'hA500_0000);
        tick();

        // Reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 32'h1111_1111 * (i + 1);
            tick();
        end
        load_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        #1 chk("idle_fetch_ready", fetch_ready, 0);
        tick();
        chk("idle_valid", instr_valid, 0);
        chk("idle_out", instr_out, 0);
        chk("idle_fault", instr_fault, 0);
        chk("idle_load_ready", load_ready, 0);
        fetch_req = 1'b0;
        load_words(32'hCAFE_0000, 4, 1'b1);
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        fetch_addr = 32'hC;
        #1 chk("reload_w0", instr_out, 32'hCAFE_0000);
`ifdef IMEM_PARITY_EN
        force dut.par_mem[3] = ~(^32'hCAFE_0003);
        tick();
        fetch_req = 1'b0;
        #1;
        chk("par_out", instr_out, 32'hCAFE_0003);
        chk("par_err", parity_err, 1);
        release dut.par_mem[3];
`else
        tick();
        fetch_req = 1'b0;
        #1;
        chk("nopar_out", instr_out, 32'hCAFE_0003);
        chk("nopar_err", parity_err, 0);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Parametrised instruction memory for the MIPS datapath, replacing the asynchronous-read instruction array. It adds a word-streaming boot-load port, a registered read with a valid/stall fetch handshake toward the decode stage, and address fault detection. It sits between the PC register and the instruction register/decode stage.

Parameters:
ADDR_WIDTH, 32, width of the byte address from the PC
DATA_WIDTH, 32, instruction word width
DEPTH_LOG2, 8, log2 of the memory depth in words (default 256 words)
NOP_WORD, 32'h0000_0000, word driven on instr_out when a fault occurs

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
load_start  input  1  request to begin a boot load
load_valid  input  1  load_data holds a valid word
load_last  input  1  marks the final word of the load (qualified by load_valid)
load_data  input  DATA_WIDTH  word to write
load_ready  output  1  accepting load words
load_done  output  1  one-cycle pulse when a load completes
fetch_req  input  1  PC presents fetch_addr
fetch_addr  input  ADDR_WIDTH  byte address
fetch_ready  output  1  request accepted this cycle
instr_stall  input  1  decode cannot take instr_out
instr_valid  output  1  instr_out is valid
instr_out  output  DATA_WIDTH  fetched instruction
instr_fault  output  1  the current instr_out came from a faulting address
parity_err  output  1  parity mismatch on the current instr_out (see Optional Feature)

Behaviour:
- Reset, synchronous and active-high: state becomes IDLE, load counter 0, and load_ready, load_done, fetch_ready, instr_valid, instr_fault and parity_err are all 0. instr_out becomes 0. Memory contents are not cleared.
- States:
  - IDLE: load_start moves to LOAD. Fetches are refused.
  - LOAD: load_ready=1. When load_valid=1 in LOAD, mem[cnt] is written with load_data and cnt increments.
    - Exit when load_last=1 is accepted, or when the word at cnt = 2**DEPTH_LOG2-1 is accepted. The counter does not wrap.
    - On exit: go to RUN, load_done=1 for exactly the next cycle, cnt=0.
    - load_start is ignored while in LOAD.
  - RUN: fetches are served. load_start in RUN goes to LOAD next cycle and clears instr_valid (flush). A fetch request in that same cycle is refused.
- Fetch handshake:
  - fetch_ready = (state==RUN) && !(instr_valid && instr_stall) && !load_start.
  - Acceptance requires fetch_req && fetch_ready. Latency is 1 cycle: on the next edge instr_valid=1 and instr_out = mem[fetch_addr[DEPTH_LOG2+1:2]].
  - While instr_valid && instr_stall, instr_out, instr_fault and parity_err hold stable.
  - If the output is consumed (instr_valid && !instr_stall) and no new fetch is accepted, instr_valid becomes 0 next cycle.
  - Back-to-back accepted fetches give one instruction per cycle.
- Fault: an accepted address faults if fetch_addr[1:0] != 0 or any bit of fetch_addr above DEPTH_LOG2+1 is set. The response is instr_valid=1, instr_out=NOP_WORD, instr_fault=1 with the same latency. Otherwise instr_fault=0.
- Simultaneous load write and fetch cannot occur, because they are separated by state.
- Reset during LOAD: the partially written memory is retained and the block returns to IDLE. A new load restarts at word 0.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined: each word stores an extra even-parity bit, computed on load writes. On a read the parity is recomputed, and parity_err=1 alongside instr_valid on a mismatch. parity_err is 0 on fault responses and holds with the output under stall.
- Undefined: no parity storage, and parity_err is tied to 0.

Test Plan:
- Load 4 words 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000 with load_last on the 4th, then fetch addresses 0x0, 0x4, 0x8, 0xC back-to-back -> load_done pulses once. The four words appear on consecutive cycles starting 1 cycle after the first accept, with instr_fault=0 throughout.
- Fetch 0x4 while instr_stall=1 for 3 cycles -> instr_out holds 0x20090002 and fetch_ready=0 during the stall. After stall release, the next fetch of 0x8 is accepted.
- Fetch 0x6 (misaligned) and 0x400 (out of range at DEPTH_LOG2=8) -> instr_out=0x00000000 and instr_fault=1 for each.
- Load the full 256 words without load_last -> exit occurs after word 255 and load_done pulses. Fetch 0x3FC returns word 255.
- Assert reset mid-load after 2 of 4 words, then fetch_req in IDLE -> fetch_ready=0 and all outputs are 0. After reload, fetch 0x0 returns the new data.
- With IMEM_PARITY_EN defined, corrupt a stored parity bit via hierarchical force and fetch that word -> parity_err=1. Without the macro, parity_err stays 0.
